cla_pipe_adder: RTL and testbench
=================================

Name: cla_pipe_adder

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor; the next generation of the 16-bit CLA datapath adder.
- Operand width, lookahead group size and pipeline depth are all configurable.
- Operands are split into STAGES equal slices. Each slice is added by a two-level lookahead tree of GROUP-bit blocks in its own pipeline stage, and the slice carry is registered into the next stage.
- Sits between the ALU operand muxes and the EX/MEM boundary, using a valid/ready handshake so the pipeline can stall.

Parameters:
- WIDTH, 16, operand/result width. WIDTH mod (STAGES*GROUP) must be 0.
- GROUP, 4, bits per lookahead block, i.e. the generate/propagate group size.
- STAGES, 2, number of pipeline stages (1..WIDTH/GROUP). This is also the latency in cycles.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous active-low reset; one clock, synchronous, active-low
- in_valid  in  1  operands/mode present
- in_ready  out  1  block can accept this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry in (add mode only)
- sub  in  1  1 = A-B (B inverted, carry in forced 1, cin ignored)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  result
- c_msb  out  1  carry into bit WIDTH-1
- cout  out  1  carry out of bit WIDTH-1
- ofl  out  1  signed overflow = cout XOR c_msb

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - Clears every stage valid bit and all output registers: out_valid=0, sum=0, c_msb=0, cout=0, ofl=0.
  - Reset dominates in_valid and out_ready in the same cycle.
  - Reset mid-operation discards all in-flight results; none is ever presented.
- Slice width is S=WIDTH/STAGES. Stage k (k=0..STAGES-1) adds bits [k*S +: S] using the carry registered from stage k-1. Stage 0 uses sub ? 1 : cin.
- Within a slice, each GROUP block produces group G/P. A second-level lookahead produces the block carries; no ripple between blocks inside a slice.
- Skew registers: the upper operand slices (B already inverted if sub) advance one stage per cycle alongside the partial results. Lower result slices are delayed so that all of sum emerges together.
- Per-stage registers: a valid bit, the carry, completed sum slices, and pending operand slices.
- Handshake:
  - Transfer in occurs when in_valid && in_ready. Transfer out occurs when out_valid && out_ready.
  - Stall rule: advance = !out_valid || out_ready. All stages shift together when advance=1 and hold when advance=0.
  - in_ready = advance, combinational from out_valid/out_ready. No combinational path from in_valid or the operands to in_ready.
  - Bubbles propagate: a stage whose upstream is not valid loads valid=0. Its data is don't-care, but holding it is preferred.
  - out_valid, sum, c_msb, cout and ofl are registered outputs. They stay stable while out_valid && !out_ready.
- Latency: an operand accepted at edge n appears with out_valid=1 after edge n+STAGES.
- Throughput: 1 result per cycle while out_ready=1. Zero bubbles inserted.
- Simultaneous transfer in and out in one cycle is legal and is the steady state.
- When STAGES=1 the block is a single registered CLA with latency 1.
- c_msb is the carry into the MSB from the last slice's internal lookahead. cout is the carry out of the last slice. Both reflect the sub inversion (cout=1 means no borrow).
- Wrap-around: sum is modulo 2^WIDTH. No saturation.
- Back-to-back add/sub mixing is per-transaction: sub travels with its operands, not as a global mode.

Test Plan:
- Reset: hold rst_n=0 for 2 clk with in_valid=1 → out_valid=0, sum=0, cout=0, ofl=0. Release and feed a=0x0001, b=0x0001, sub=0, cin=0 → after 2 edges out_valid=1, sum=0x0002, cout=0, ofl=0.
- Carry across slice boundary: a=0x00FF, b=0x0001, cin=0 → sum=0x0100, cout=0. Then a=0xFFFF, b=0x0001 → sum=0x0000, cout=1, c_msb=1, ofl=0.
- Signed overflow and subtract:
  - a=0x7FFF, b=0x0001, add → sum=0x8000, c_msb=1, cout=0, ofl=1.
  - a=0x8000, b=0x0001, sub=1 → sum=0x7FFF, cout=1, c_msb=0, ofl=1.
  - a=0x0003, b=0x0005, sub=1 → sum=0xFFFE, cout=0, ofl=0.
- Backpressure: stream 4 transactions with out_ready=0 for 3 cycles → in_ready=0 once out_valid=1. sum holds the first result unchanged. Releasing out_ready delivers all 4 in order, one per cycle, none lost or duplicated.
- Bubble and reset mid-flight: in_valid toggling 1,0,1 gives out_valid 1,0,1 with 2-cycle skew. Asserting rst_n=0 while 2 results are in flight → no result ever emerges and out_valid=0 the cycle after reset.
- Parameter sweep: WIDTH=32, GROUP=4, STAGES=4 with random plus corner operands (0, all-ones, 0x80000000) vs a reference model → latency 4. Matching sum/cout/c_msb/ofl for 10k vectors at full throughput.

Source files
------------

// File: rtl/cla_pipe_adder_if.sv
// Operand/result handshake bundle for cla_pipe_adder: the producer drives operands,
// the consumer drives out_ready, and the adder returns results.
interface cla_pipe_adder_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             c_msb;
   logic             cout;
   logic             ofl;

   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, sum, c_msb, cout, ofl
   );

   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, sum, c_msb, cout, ofl
   );
endinterface

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor. Each stage adds one WIDTH/STAGES slice
// with a two-level lookahead tree and hands its carry to the next stage.
module cla_pipe_adder #(
   parameter int WIDTH  = 16,
   parameter int GROUP  = 4,
   parameter int STAGES = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   cla_pipe_adder_if.slave io
);
   localparam int S  = WIDTH / STAGES;
   localparam int NB = S / GROUP;

   if (WIDTH % (STAGES * GROUP) != 0) begin : g_bad_params
      $error("cla_pipe_adder: WIDTH must be a multiple of STAGES*GROUP");
   end

   logic advance;

   // The whole pipeline moves as one; only the output register can stall it.
   assign advance     = !io.out_valid || io.out_ready;
   assign io.in_ready = advance;

   // Returns carries c[0..S] of one slice, all as flat sums of products: block G/P first,
   // then block carries from a second lookahead level, then bit carries inside each block.
   function automatic logic [S:0] slice_carry(
      input logic [S-1:0] gen,
      input logic [S-1:0] prop,
      input logic         c0
   );
      logic [NB-1:0] bg;
      logic [NB-1:0] bp;
      logic [NB:0]   cb;
      logic [S:0]    cv;
      logic          t;
      for (int j = 0; j < NB; j++) begin
         bg[j] = 1'b0;
         bp[j] = 1'b1;
         for (int i = 0; i < GROUP; i++) begin
            t = gen[j*GROUP+i];
            for (int m = i + 1; m < GROUP; m++) t = t & prop[j*GROUP+m];
            bg[j] = bg[j] | t;
            bp[j] = bp[j] & prop[j*GROUP+i];
         end
      end
      for (int j = 0; j <= NB; j++) begin
         t = c0;
         for (int m = 0; m < j; m++) t = t & bp[m];
         cb[j] = t;
         for (int i = 0; i < j; i++) begin
            t = bg[i];
            for (int m = i + 1; m < j; m++) t = t & bp[m];
            cb[j] = cb[j] | t;
         end
      end
      for (int j = 0; j < NB; j++) begin
         for (int i = 0; i < GROUP; i++) begin
            t = cb[j];
            for (int m = 0; m < i; m++) t = t & prop[j*GROUP+m];
            cv[j*GROUP+i] = t;
            for (int k = 0; k < i; k++) begin
               t = gen[j*GROUP+k];
               for (int m = k + 1; m < i; m++) t = t & prop[j*GROUP+m];
               cv[j*GROUP+i] = cv[j*GROUP+i] | t;
            end
         end
      end
      cv[S] = cb[NB];
      return cv;
   endfunction

   for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      localparam int LO = gi * S;

      logic              v_in;
      logic              c_in;
      logic [WIDTH-1:LO] a_in;
      logic [WIDTH-1:LO] b_in;
      logic [LO+S-1:0]   s_cat;
      logic [S-1:0]      g;
      logic [S-1:0]      p;
      logic [S-1:0]      s_d;
      logic [S:0]        c;
      logic              v_q;
      logic              c_q;
      logic [LO+S-1:0]   s_q;

      if (gi == 0) begin : g_head
         // Subtraction is A + ~B + 1; the inverted B travels with its transaction.
         assign v_in  = io.in_valid;
         assign c_in  = io.sub | io.cin;
         assign a_in  = io.a;
         assign b_in  = io.b ^ {WIDTH{io.sub}};
         assign s_cat = s_d;
      end else begin : g_tail
         assign v_in  = g_stage[gi-1].v_q;
         assign c_in  = g_stage[gi-1].c_q;
         assign a_in  = g_stage[gi-1].g_pend.a_q;
         assign b_in  = g_stage[gi-1].g_pend.b_q;
         assign s_cat = {s_d, g_stage[gi-1].s_q};
      end

      assign g   = a_in[LO +: S] & b_in[LO +: S];
      assign p   = a_in[LO +: S] ^ b_in[LO +: S];
      assign c   = slice_carry(g, p, c_in);
      assign s_d = p ^ c[S-1:0];

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            v_q <= 1'b0;
            c_q <= 1'b0;
            s_q <= '0;
         end else if (advance) begin
            v_q <= v_in;
            if (v_in) begin
               c_q <= c[S];
               s_q <= s_cat;
            end
         end
      end

      if (gi < STAGES - 1) begin : g_pend
         logic [WIDTH-1:LO+S] a_q;
         logic [WIDTH-1:LO+S] b_q;

         always_ff @(posedge clk) begin
            if (advance && v_in) begin
               a_q <= a_in[WIDTH-1:LO+S];
               b_q <= b_in[WIDTH-1:LO+S];
            end
         end
      end else begin : g_last
         logic c_msb_q;
         logic ofl_q;

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               c_msb_q <= 1'b0;
               ofl_q   <= 1'b0;
            end else if (advance && v_in) begin
               c_msb_q <= c[S-1];
               ofl_q   <= c[S] ^ c[S-1];
            end
         end
      end
   end

   assign io.out_valid = g_stage[STAGES-1].v_q;
   assign io.sum       = g_stage[STAGES-1].s_q;
   assign io.cout      = g_stage[STAGES-1].c_q;
   assign io.c_msb     = g_stage[STAGES-1].g_last.c_msb_q;
   assign io.ofl       = g_stage[STAGES-1].g_last.ofl_q;
endmodule

// File: tb/tb_cla_pipe_adder.sv
// Self-checking bench for cla_pipe_adder: a 16-bit/2-stage instance for directed
// scenarios and a 32-bit/4-stage instance for a streamed random/corner sweep.
module tb_cla_pipe_adder;
   typedef struct packed {
      logic [31:0] s;
      logic        cm;
      logic        co;
      logic        of;
   } res_t;

   typedef struct packed {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic        sub;
      res_t        e;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   res_t q16[$];
   res_t q32[$];

   always #5 clk = ~clk;

   cla_pipe_adder_if #(.WIDTH(16)) if16 ();
   cla_pipe_adder_if #(.WIDTH(32)) if32 ();

   cla_pipe_adder #(.WIDTH(16), .GROUP(4), .STAGES(2)) u16 (
      .clk   (clk),
      .rst_n (rst_n),
      .io    (if16)
   );

   cla_pipe_adder #(.WIDTH(32), .GROUP(4), .STAGES(4)) u32 (
      .clk   (clk),
      .rst_n (rst_n),
      .io    (if32)
   );

   // Arithmetic reference: plain wide addition, with the MSB carry taken from the low bits.
   function automatic res_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                  input logic cin, input logic sub);
      logic [63:0] mask;
      logic [63:0] lmask;
      logic [63:0] bb;
      logic [63:0] full;
      logic [63:0] low;
      logic        ci;
      res_t        r;
      mask  = (64'd1 << w) - 64'd1;
      lmask = (64'd1 << (w - 1)) - 64'd1;
      bb    = (sub ? ~{32'd0, b} : {32'd0, b}) & mask;
      ci    = sub | cin;
      full  = ({32'd0, a} & mask) + bb + {63'd0, ci};
      low   = ({32'd0, a} & lmask) + (bb & lmask) + {63'd0, ci};
      r.s   = full[31:0] & mask[31:0];
      r.co  = full[w];
      r.cm  = low[w-1];
      r.of  = r.co ^ r.cm;
      return r;
   endfunction

   function automatic res_t mk(input logic [15:0] s, input logic cm, input logic co, input logic of);
      res_t r;
      r.s  = {16'd0, s};
      r.cm = cm;
      r.co = co;
      r.of = of;
      return r;
   endfunction

   task automatic drive16(input logic v, input logic [15:0] a, input logic [15:0] b,
                          input logic c, input logic s);
      if16.in_valid = v;
      if16.a        = a;
      if16.b        = b;
      if16.cin      = c;
      if16.sub      = s;
   endtask

   // One clock: report what transferred in/out at this edge, then return #1 after it.
   task automatic tick16(output bit fin, output bit got, output res_t r);
      @(negedge clk);
      fin = 1'b0;
      got = 1'b0;
      r   = '0;
      if (rst_n !== 1'b1) begin
         q16.delete();
      end else begin
         fin = (if16.in_valid && if16.in_ready);
         if (if16.out_valid && if16.out_ready) begin
            got  = 1'b1;
            r.s  = {16'd0, if16.sum};
            r.cm = if16.c_msb;
            r.co = if16.cout;
            r.of = if16.ofl;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic tick32(output bit fin, output bit got, output res_t r);
      @(negedge clk);
      fin = 1'b0;
      got = 1'b0;
      r   = '0;
      if (rst_n !== 1'b1) begin
         q32.delete();
      end else begin
         fin = (if32.in_valid && if32.in_ready);
         if (if32.out_valid && if32.out_ready) begin
            got  = 1'b1;
            r.s  = if32.sum;
            r.cm = if32.c_msb;
            r.co = if32.cout;
            r.of = if32.ofl;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      bit   fin, got;
      res_t r, e;
      rst_n = 1'b0;
      if16.out_ready = 1'b1;
      drive16(1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
      repeat (2) tick16(fin, got, r);
      checks++;
      if ({if16.out_valid, if16.sum, if16.c_msb, if16.cout, if16.ofl} !== 20'd0) begin
         errors++;
         $display("FAIL reset_outputs: got valid=%b sum=%h c_msb=%b cout=%b ofl=%b, expected all zero",
                  if16.out_valid, if16.sum, if16.c_msb, if16.cout, if16.ofl);
      end
      checks++;
      if (if32.out_valid !== 1'b0 || if32.sum !== 32'd0) begin
         errors++;
         $display("FAIL reset_outputs32: got valid=%b sum=%h, expected 0 and 0", if32.out_valid, if32.sum);
      end
      rst_n = 1'b1;
      drive16(1'b1, 16'h0001, 16'h0001, 1'b0, 1'b0);
      tick16(fin, got, r);
      checks++;
      if (fin !== 1'b1) begin
         errors++;
         $display("FAIL reset_accept: got fire=%b, expected 1", fin);
      end else begin
         q16.push_back(mk(16'h0002, 1'b0, 1'b0, 1'b0));
      end
      drive16(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
      checks++;
      if (if16.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL latency_early: got out_valid=%b after 1 edge, expected 0", if16.out_valid);
      end
      tick16(fin, got, r);
      checks++;
      if (if16.out_valid !== 1'b1) begin
         errors++;
         $display("FAIL latency_due: got out_valid=%b after 2 edges, expected 1", if16.out_valid);
      end
      tick16(fin, got, r);
      checks++;
      if (!got || q16.size() == 0) begin
         errors++;
         $display("FAIL reset_first_result: got transfer=%b, expected 1 result", got);
      end else begin
         e = q16.pop_front();
         if (r !== e) begin
            errors++;
            $display("FAIL reset_first_result: got sum=%h cm=%b co=%b of=%b, expected sum=%h cm=%b co=%b of=%b",
                     r.s, r.cm, r.co, r.of, e.s, e.cm, e.co, e.of);
         end
      end
      $display("test_reset: done, checks=%0d errors=%0d", checks, errors);
   endtask

   // Slice-boundary carries, signed overflow and add/sub mixed back to back.
   task automatic test_arith();
      vec_t tbl [6];
      bit   fin, got;
      res_t r, e;
      int   i, n;
      tbl[0] = '{a: 16'h00FF, b: 16'h0001, cin: 1'b0, sub: 1'b0, e: mk(16'h0100, 1'b0, 1'b0, 1'b0)};
      tbl[1] = '{a: 16'hFFFF, b: 16'h0001, cin: 1'b0, sub: 1'b0, e: mk(16'h0000, 1'b1, 1'b1, 1'b0)};
      tbl[2] = '{a: 16'h7FFF, b: 16'h0001, cin: 1'b0, sub: 1'b0, e: mk(16'h8000, 1'b1, 1'b0, 1'b1)};
      tbl[3] = '{a: 16'h8000, b: 16'h0001, cin: 1'b0, sub: 1'b1, e: mk(16'h7FFF, 1'b0, 1'b1, 1'b1)};
      tbl[4] = '{a: 16'h0003, b: 16'h0005, cin: 1'b1, sub: 1'b1, e: mk(16'hFFFE, 1'b0, 1'b0, 1'b0)};
      tbl[5] = '{a: 16'h1234, b: 16'h0001, cin: 1'b1, sub: 1'b0, e: mk(16'h1236, 1'b0, 1'b0, 1'b0)};
      if16.out_ready = 1'b1;
      i = 0;
      n = 0;
      for (int cyc = 0; cyc < 40 && n < 6; cyc++) begin
         if (i < 6) drive16(1'b1, tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub);
         else       drive16(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
         tick16(fin, got, r);
         if (fin && i < 6) begin
            q16.push_back(tbl[i].e);
            i++;
         end
         if (got) begin
            checks++;
            if (q16.size() == 0) begin
               errors++;
               $display("FAIL arith_extra: got unexpected result sum=%h, expected none", r.s);
            end else begin
               e = q16.pop_front();
               if (r !== e) begin
                  errors++;
                  $display("FAIL arith_vec%0d: got sum=%h cm=%b co=%b of=%b, expected sum=%h cm=%b co=%b of=%b",
                           n, r.s, r.cm, r.co, r.of, e.s, e.cm, e.co, e.of);
               end
            end
            n++;
         end
      end
      checks++;
      if (n != 6) begin
         errors++;
         $display("FAIL arith_count: got %0d results, expected 6", n);
      end
      $display("test_arith: done, %0d results, errors=%0d", n, errors);
   endtask

   task automatic test_backpressure();
      bit          fin, got;
      res_t        r, e;
      logic [15:0] av;
      int          i, n, last;
      i = 0;
      n = 0;
      last = -1;
      if16.out_ready = 1'b0;
      for (int cyc = 0; cyc < 25 && n < 4; cyc++) begin
         if (cyc == 5) if16.out_ready = 1'b1;
         av = 16'(16'h1111 * (i + 1));
         drive16(i < 4, av, 16'h0001, 1'b0, 1'b0);
         tick16(fin, got, r);
         if (fin && i < 4) begin
            q16.push_back(mk(av + 16'h0001, 1'b0, 1'b0, 1'b0));
            i++;
         end
         if (got) begin
            checks++;
            if (q16.size() == 0) begin
               errors++;
               $display("FAIL bp_extra: got unexpected result sum=%h, expected none", r.s);
            end else begin
               e = q16.pop_front();
               if (r !== e) begin
                  errors++;
                  $display("FAIL bp_order%0d: got sum=%h, expected sum=%h", n, r.s, e.s);
               end
            end
            checks++;
            if (last >= 0 && cyc != last + 1) begin
               errors++;
               $display("FAIL bp_gap: got result at cycle %0d, expected cycle %0d", cyc, last + 1);
            end
            last = cyc;
            n++;
         end
         if (cyc < 5 && if16.out_valid === 1'b1) begin
            checks++;
            if (if16.in_ready !== 1'b0) begin
               errors++;
               $display("FAIL bp_in_ready: got in_ready=%b while stalled, expected 0", if16.in_ready);
            end
            checks++;
            if (if16.sum !== 16'h1112) begin
               errors++;
               $display("FAIL bp_hold: got sum=%h while stalled, expected 1112", if16.sum);
            end
         end
      end
      drive16(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
      checks++;
      if (n != 4 || i != 4) begin
         errors++;
         $display("FAIL bp_count: got %0d accepted / %0d delivered, expected 4 / 4", i, n);
      end
      $display("test_backpressure: done, %0d results, errors=%0d", n, errors);
   endtask

   task automatic test_bubble();
      bit          fin, got;
      res_t        r, e;
      logic [2:0]  pat;
      logic [15:0] av;
      logic        want;
      int          n;
      pat = 3'b101;
      n = 0;
      if16.out_ready = 1'b1;
      for (int t = 0; t < 7; t++) begin
         av = 16'(16'h0100 * t + 5);
         drive16((t < 3) ? pat[t] : 1'b0, av, 16'h0010, 1'b0, 1'b0);
         tick16(fin, got, r);
         if (fin) q16.push_back(mk(av + 16'h0010, 1'b0, 1'b0, 1'b0));
         want = (t >= 1 && t <= 3) ? pat[t-1] : 1'b0;
         checks++;
         if (if16.out_valid !== want) begin
            errors++;
            $display("FAIL bubble_valid%0d: got out_valid=%b, expected %b", t, if16.out_valid, want);
         end
         if (got) begin
            checks++;
            if (q16.size() == 0) begin
               errors++;
               $display("FAIL bubble_extra: got unexpected result sum=%h, expected none", r.s);
            end else begin
               e = q16.pop_front();
               if (r !== e) begin
                  errors++;
                  $display("FAIL bubble_data: got sum=%h, expected sum=%h", r.s, e.s);
               end
            end
            n++;
         end
      end
      checks++;
      if (n != 2) begin
         errors++;
         $display("FAIL bubble_count: got %0d results, expected 2", n);
      end
      $display("test_bubble: done, %0d results, errors=%0d", n, errors);
   endtask

   task automatic test_reset_midflight();
      bit   fin, got;
      res_t r;
      int   extra;
      extra = 0;
      if16.out_ready = 1'b1;
      drive16(1'b1, 16'h0A0A, 16'h0101, 1'b0, 1'b0);
      tick16(fin, got, r);
      if (fin) q16.push_back(mk(16'h0B0B, 1'b0, 1'b0, 1'b0));
      drive16(1'b1, 16'h0B0B, 16'h0101, 1'b0, 1'b0);
      tick16(fin, got, r);
      if (fin) q16.push_back(mk(16'h0C0C, 1'b0, 1'b0, 1'b0));
      rst_n = 1'b0;
      tick16(fin, got, r);
      checks++;
      if (if16.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL midreset_valid: got out_valid=%b after reset, expected 0", if16.out_valid);
      end
      rst_n = 1'b1;
      drive16(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
      for (int t = 0; t < 6; t++) begin
         tick16(fin, got, r);
         if (got) extra++;
      end
      checks++;
      if (extra != 0) begin
         errors++;
         $display("FAIL midreset_flush: got %0d results after reset, expected 0", extra);
      end
      $display("test_reset_midflight: done, errors=%0d", errors);
   endtask

   task automatic test_sweep32();
      localparam int N = 10000;
      logic [31:0] cv [5];
      logic [31:0] av, bv;
      logic        ci, sb;
      bit          fin, got;
      res_t        r, e;
      int          i, n, cyc, first_fin, first_got, bad;
      cv[0] = 32'h0000_0000;
      cv[1] = 32'hFFFF_FFFF;
      cv[2] = 32'h8000_0000;
      cv[3] = 32'h7FFF_FFFF;
      cv[4] = 32'h0000_0001;
      i = 0;
      n = 0;
      bad = 0;
      first_fin = -1;
      first_got = -1;
      if32.out_ready = 1'b1;
      for (cyc = 0; cyc < N + 100 && n < N; cyc++) begin
         if (i < 75) begin
            av = cv[i / 15];
            bv = cv[(i / 3) % 5];
            ci = ((i % 3) == 1);
            sb = ((i % 3) == 2);
         end else begin
            av = $urandom;
            bv = $urandom;
            ci = 1'($urandom_range(0, 1));
            sb = 1'($urandom_range(0, 1));
         end
         if32.in_valid = (i < N);
         if32.a        = av;
         if32.b        = bv;
         if32.cin      = ci;
         if32.sub      = sb;
         tick32(fin, got, r);
         if (fin && i < N) begin
            q32.push_back(model(32, av, bv, ci, sb));
            if (first_fin < 0) first_fin = cyc;
            i++;
         end
         if (got) begin
            if (first_got < 0) first_got = cyc;
            checks++;
            if (q32.size() == 0) begin
               errors++;
               $display("FAIL sweep_extra: got unexpected result sum=%h, expected none", r.s);
            end else begin
               e = q32.pop_front();
               if (r !== e) begin
                  errors++;
                  bad++;
                  if (bad <= 10)
                     $display("FAIL sweep_vec%0d: got sum=%h cm=%b co=%b of=%b, expected sum=%h cm=%b co=%b of=%b",
                              n, r.s, r.cm, r.co, r.of, e.s, e.cm, e.co, e.of);
               end
            end
            n++;
         end
      end
      if32.in_valid = 1'b0;
      checks++;
      if (first_got - first_fin != 4) begin
         errors++;
         $display("FAIL sweep_latency: got first result %0d cycles after accept, expected 4",
                  first_got - first_fin);
      end
      checks++;
      if (n != N) begin
         errors++;
         $display("FAIL sweep_count: got %0d results, expected %0d", n, N);
      end
      checks++;
      if (cyc != N + 4) begin
         errors++;
         $display("FAIL sweep_throughput: got %0d cycles for %0d vectors, expected %0d", cyc, N, N + 4);
      end
      $display("test_sweep32: done, %0d results, errors=%0d", n, errors);
   endtask

   initial begin
      rst_n = 1'b0;
      drive16(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
      if16.out_ready = 1'b1;
      if32.in_valid  = 1'b0;
      if32.a         = 32'd0;
      if32.b         = 32'd0;
      if32.cin       = 1'b0;
      if32.sub       = 1'b0;
      if32.out_ready = 1'b1;
      test_reset();
      test_arith();
      test_backpressure();
      test_bubble();
      test_reset_midflight();
      test_sweep32();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      errors++;
      $display("FAIL watchdog: time limit reached, got no completion, expected finish");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "time limit reached");
   end
endmodule
